// File: rtl/sha_out_pkg.sv
// Shared widths and state encoding for the SHA output serializer and the matching
// serial-to-parallel collector.
package sha_out_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 8;
  localparam int BLOCK_W   = WORD_W * NUM_WORDS;
  localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Position of the word sent at step `count`: the highest word goes out first.
  function automatic logic [CNT_W-1:0] word_index(input logic [CNT_W-1:0] count);
    return CNT_W'(NUM_WORDS - 1) - count;
  endfunction

endpackage

// File: rtl/pts_word_cnt.sv
// Word counter for the serializer: synchronous clear, enable, and a flag on the
// final word. It holds at the final value instead of wrapping.
module pts_word_cnt #(
  parameter int NUM_WORDS = 8,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  assign last  = (count_reg == CNT_W'(NUM_WORDS - 1));
  assign count = count_reg;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en && !last) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/pts_sr_8.sv
// Parallel-to-serial block sender: captures NUM_WORDS words on load and streams
// them highest word first under a valid/ready handshake, then pulses done.
module pts_sr_8 #(
  parameter int NUM_WORDS = sha_out_pkg::NUM_WORDS,
  parameter int WORD_W    = sha_out_pkg::WORD_W
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        load,
  input  logic [NUM_WORDS*WORD_W-1:0] parallel_in,
  input  logic                        out_ready,
  output logic [WORD_W-1:0]           serial_out,
  output logic                        out_valid,
  output logic                        busy,
  output logic                        done
);

  import sha_out_pkg::state_t;
  import sha_out_pkg::IDLE;
  import sha_out_pkg::SEND;

  localparam int BLK_W   = NUM_WORDS * WORD_W;
  localparam int CNT_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [BLK_W-1:0] data_reg;
  logic [BLK_W-1:0] data_next;
  logic             done_reg;
  logic             done_next;

  logic             load_accept;
  logic             xfer;
  logic             finish;
  logic [CNT_W-1:0] count;
  logic             cnt_last;
  logic [CNT_W-1:0] word_sel;

  logic [WORD_W-1:0] words [NUM_WORDS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_words
      assign words[gi] = data_reg[gi*WORD_W +: WORD_W];
    end
  endgenerate

  assign load_accept = (state_reg == IDLE) && load;
  assign xfer        = (state_reg == SEND) && out_ready;
  assign finish      = xfer && cnt_last;
  assign word_sel    = LAST_IDX - count;

  // Counter is cleared both on capture and on completion so IDLE always sits at zero.
  pts_word_cnt #(
    .NUM_WORDS (NUM_WORDS),
    .CNT_W     (CNT_W)
  ) u_word_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (load_accept || finish),
    .en    (xfer),
    .count (count),
    .last  (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load) begin
          state_next = SEND;
          data_next  = parallel_in;
        end
      end
      SEND: begin
        if (finish) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid  = 1'b0;
    busy       = 1'b0;
    serial_out = '0;
    if (state_reg == SEND) begin
      out_valid  = 1'b1;
      busy       = 1'b1;
      serial_out = words[word_sel];
    end
  end

  assign done = done_reg;

endmodule
